// File: rtl/free_list_multi.sv
// rtl/free_list_multi.sv - multi-lane circular free list of physical register numbers
module free_list_multi #(
  parameter int NUM_PR   = 64,
  parameter int PR_W     = 6,
  parameter int WIDTH    = 4,
  parameter int NUM_ARCH = 16,
  parameter int PTR_W    = PR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [WIDTH-1:0]      alloc_req,
  output logic                  alloc_gnt,
  output logic [WIDTH*PR_W-1:0] alloc_pr,
  input  logic [WIDTH-1:0]      free_vld,
  input  logic [WIDTH*PR_W-1:0] free_pr,
  input  logic                  flush,
  input  logic [PTR_W-1:0]      flush_ptr,
  output logic [PTR_W-1:0]      alloc_ptr,
  output logic [PR_W:0]         free_cnt,
  output logic                  list_empty,
  output logic                  overflow_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [PR_W-1:0]  r_list [NUM_PR];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic             r_ovf;

  // w_*_pre[k] = number of set bits below lane k; entry WIDTH is the total
  logic [CNT_W-1:0] w_req_pre  [WIDTH+1];
  logic [CNT_W-1:0] w_free_pre [WIDTH+1];
  logic [PTR_W-1:0] w_free_cnt;
  logic [PTR_W:0]   w_cnt_next;
  logic             w_gnt;
  logic             w_ovf;

  // Prefix popcounts used to compact lanes onto consecutive list slots
  always_comb begin
    w_req_pre[0]  = '0;
    w_free_pre[0] = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_req_pre[k+1]  = w_req_pre[k]  + CNT_W'(alloc_req[k]);
      w_free_pre[k+1] = w_free_pre[k] + CNT_W'(free_vld[k]);
    end
  end

  // Free count from registered pointers only, so a free never feeds a same-cycle grant
  always_comb begin
    w_free_cnt = r_tail - r_head;
    w_gnt      = rst_n && !stall && !flush && (PTR_W'(w_req_pre[WIDTH]) <= w_free_cnt);
    w_cnt_next = {1'b0, w_free_cnt} + (PTR_W+1)'(w_free_pre[WIDTH])
               - (w_gnt ? (PTR_W+1)'(w_req_pre[WIDTH]) : '0);
    w_ovf      = w_cnt_next > (PTR_W+1)'(NUM_PR);
  end

  // Lane k reads the head entry offset by the requests in lower lanes
  always_comb begin
    alloc_pr = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc_req[k] && w_gnt) begin
        alloc_pr[k*PR_W +: PR_W] = r_list[r_head[PR_W-1:0] + PR_W'(w_req_pre[k])];
      end
    end
  end

  // Head pointer: flush restores a checkpoint, otherwise advances by granted lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= PTR_W'(NUM_ARCH);
    end else if (!stall) begin
      if (flush) begin
        r_head <= flush_ptr;
      end else if (w_gnt) begin
        r_head <= r_head + PTR_W'(w_req_pre[WIDTH]);
      end
    end
  end

  // Tail side: append freed PRs, or drop them all and latch the sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PR; i++) begin
        r_list[i] <= PR_W'(i);
      end
      r_tail <= PTR_W'(NUM_PR);
      r_ovf  <= 1'b0;
    end else if (!stall) begin
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end else begin
        for (int k = 0; k < WIDTH; k++) begin
          if (free_vld[k]) begin
            r_list[r_tail[PR_W-1:0] + PR_W'(w_free_pre[k])] <= free_pr[k*PR_W +: PR_W];
          end
        end
        r_tail <= r_tail + PTR_W'(w_free_pre[WIDTH]);
      end
    end
  end

  assign alloc_gnt    = w_gnt;
  assign alloc_ptr    = r_head;
  assign free_cnt     = w_free_cnt;
  assign list_empty   = (w_free_cnt == '0);
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_free_list_multi.sv
// tb/tb_free_list_multi.sv - directed self-checking bench for free_list_multi
module tb_free_list_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, flush, alloc_gnt, list_empty, overflow_err;
  logic [3:0]  alloc_req, free_vld;
  logic [23:0] alloc_pr, free_pr;
  logic [6:0]  flush_ptr, alloc_ptr, free_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  exp_l [4];

  free_list_multi dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_pr(alloc_pr),
    .free_vld(free_vld), .free_pr(free_pr),
    .flush(flush), .flush_ptr(flush_ptr),
    .alloc_ptr(alloc_ptr), .free_cnt(free_cnt),
    .list_empty(list_empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = '0; free_vld = '0; free_pr = '0;
    flush = 1'b0; flush_ptr = '0; stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    alloc_req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt got %0b exp 0", alloc_gnt); end
    n_vec++; if (alloc_ptr !== 7'd16) begin n_err++; $display("FAIL reset_ptr got %0d exp 16", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd48) begin n_err++; $display("FAIL reset_cnt got %0d exp 48", free_cnt); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
    n_vec++; if (list_empty !== 1'b0) begin n_err++; $display("FAIL reset_empty got %0b exp 0", list_empty); end
    step();
    rst_n = 1'b1;
    alloc_req = '0;
    #1;
  endtask

  task automatic test_alloc_all();
    do_reset();
    alloc_req = 4'b1111;
    #1;
    exp_l[0] = 6'd16; exp_l[1] = 6'd17; exp_l[2] = 6'd18; exp_l[3] = 6'd19;
    n_vec++; if (alloc_gnt !== 1'b1) begin n_err++; $display("FAIL all_gnt got %0b exp 1", alloc_gnt); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL all_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    alloc_req = '0;
    #1;
    n_vec++; if (alloc_ptr !== 7'd20) begin n_err++; $display("FAIL all_ptr got %0d exp 20", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd44) begin n_err++; $display("FAIL all_cnt got %0d exp 44", free_cnt); end
  endtask

  task automatic test_alloc_sparse();
    do_reset();
    alloc_req = 4'b1010;
    #1;
    exp_l[0] = 6'd0; exp_l[1] = 6'd16; exp_l[2] = 6'd0; exp_l[3] = 6'd17;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL sparse_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    alloc_req = '0;
    #1;
    n_vec++; if (alloc_ptr !== 7'd18) begin n_err++; $display("FAIL sparse_ptr got %0d exp 18", alloc_ptr); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      alloc_req = 4'b1111;
      step();
    end
    alloc_req = 4'b0011;
    step();
    alloc_req = 4'b0111;
    #1;
    n_vec++; if (free_cnt !== 7'd2) begin n_err++; $display("FAIL drain_cnt got %0d exp 2", free_cnt); end
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL drain_gnt0 got %0b exp 0", alloc_gnt); end
    n_vec++; if (alloc_pr !== 24'd0) begin n_err++; $display("FAIL drain_lanes0 got %h exp 0", alloc_pr); end
    step();
    n_vec++; if (alloc_ptr !== 7'd62) begin n_err++; $display("FAIL drain_hold got %0d exp 62", alloc_ptr); end
    alloc_req = 4'b0011;
    #1;
    exp_l[0] = 6'd62; exp_l[1] = 6'd63; exp_l[2] = 6'd0; exp_l[3] = 6'd0;
    n_vec++; if (alloc_gnt !== 1'b1) begin n_err++; $display("FAIL drain_gnt1 got %0b exp 1", alloc_gnt); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL drain_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    alloc_req = '0;
    #1;
    n_vec++; if (list_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %0b exp 1", list_empty); end
    n_vec++; if (alloc_ptr !== 7'd64) begin n_err++; $display("FAIL drain_ptr got %0d exp 64", alloc_ptr); end
  endtask

  // Continues from the drained state: head = tail = 64; refill list[0..61] = 0..61
  task automatic test_free_wrap();
    for (int c = 0; c < 15; c++) begin
      free_vld = 4'b1111;
      for (int k = 0; k < 4; k++) free_pr[k*6 +: 6] = 6'(c*4 + k);
      step();
    end
    free_vld = 4'b0011;
    free_pr  = {6'd0, 6'd0, 6'd61, 6'd60};
    step();
    free_vld = '0;
    #1;
    n_vec++; if (free_cnt !== 7'd62) begin n_err++; $display("FAIL wrap_cnt62 got %0d exp 62", free_cnt); end
    free_vld = 4'b0101;
    free_pr  = {6'd63, 6'd9, 6'd63, 6'd5};
    step();
    free_vld = '0;
    #1;
    n_vec++; if (free_cnt !== 7'd64) begin n_err++; $display("FAIL wrap_cnt64 got %0d exp 64", free_cnt); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got %0b exp 0", overflow_err); end
  endtask

  // Continues at free_cnt = 64 with head index 0
  task automatic test_overflow();
    free_vld = 4'b0001;
    free_pr  = {18'd0, 6'd33};
    step();
    free_vld = '0;
    #1;
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set got %0b exp 1", overflow_err); end
    n_vec++; if (free_cnt !== 7'd64) begin n_err++; $display("FAIL ovf_cnt got %0d exp 64", free_cnt); end
    step();
    alloc_req = 4'b1111;
    #1;
    exp_l[0] = 6'd0; exp_l[1] = 6'd1; exp_l[2] = 6'd2; exp_l[3] = 6'd3;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL ovf_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    for (int c = 0; c < 14; c++) step();
    alloc_req = 4'b0011;
    step();
    #1;
    exp_l[0] = 6'd5; exp_l[1] = 6'd9; exp_l[2] = 6'd0; exp_l[3] = 6'd0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL wrapread_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    alloc_req = '0;
    #1;
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_held got %0b exp 1", overflow_err); end
    n_vec++; if (list_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got %0b exp 1", list_empty); end
  endtask

  task automatic test_async_reset();
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL arst_ovf got %0b exp 0", overflow_err); end
    n_vec++; if (alloc_ptr !== 7'd16) begin n_err++; $display("FAIL arst_ptr got %0d exp 16", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd48) begin n_err++; $display("FAIL arst_cnt got %0d exp 48", free_cnt); end
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 4'b1111;
    step();
    step();
    alloc_req = 4'b1111;
    flush = 1'b1; flush_ptr = 7'd16;
    free_vld = 4'b0001; free_pr = {18'd0, 6'd40};
    #1;
    n_vec++; if (alloc_ptr !== 7'd24) begin n_err++; $display("FAIL flush_pre_ptr got %0d exp 24", alloc_ptr); end
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL flush_gnt got %0b exp 0", alloc_gnt); end
    step();
    flush = 1'b0; free_vld = '0;
    #1;
    n_vec++; if (alloc_ptr !== 7'd16) begin n_err++; $display("FAIL flush_ptr got %0d exp 16", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd49) begin n_err++; $display("FAIL flush_cnt got %0d exp 49", free_cnt); end
    exp_l[0] = 6'd16; exp_l[1] = 6'd17; exp_l[2] = 6'd18; exp_l[3] = 6'd19;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL flush_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    step();
    alloc_req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1'b1;
    alloc_req = 4'b1111;
    free_vld = 4'b0001; free_pr = {18'd0, 6'd7};
    #1;
    n_vec++; if (alloc_gnt !== 1'b0) begin n_err++; $display("FAIL stall_gnt got %0b exp 0", alloc_gnt); end
    n_vec++; if (alloc_pr !== 24'd0) begin n_err++; $display("FAIL stall_lanes got %h exp 0", alloc_pr); end
    step();
    step();
    n_vec++; if (alloc_ptr !== 7'd16) begin n_err++; $display("FAIL stall_ptr got %0d exp 16", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd48) begin n_err++; $display("FAIL stall_cnt got %0d exp 48", free_cnt); end
    stall = 1'b0; free_vld = '0;
    #1;
    exp_l[0] = 6'd16; exp_l[1] = 6'd17; exp_l[2] = 6'd18; exp_l[3] = 6'd19;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (alloc_pr[k*6 +: 6] !== exp_l[k]) begin n_err++; $display("FAIL unstall_lane%0d got %0d exp %0d", k, alloc_pr[k*6 +: 6], exp_l[k]); end
    end
    alloc_req = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_req = 4'b1111;
    free_vld  = 4'b1111;
    free_pr   = {6'd20, 6'd21, 6'd22, 6'd23};
    step();
    alloc_req = '0; free_vld = '0;
    #1;
    n_vec++; if (alloc_ptr !== 7'd20) begin n_err++; $display("FAIL b2b_ptr got %0d exp 20", alloc_ptr); end
    n_vec++; if (free_cnt !== 7'd48) begin n_err++; $display("FAIL b2b_cnt got %0d exp 48", free_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alloc_all();
    test_alloc_sparse();
    test_drain();
    test_free_wrap();
    test_overflow();
    test_async_reset();
    test_flush();
    test_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
